bisr_weight_loader: RTL and testbench

Tile sequencer directly upstream of the BISR weight-allocation stage. It accepts one weight tile (SYSTOLIC_SIZE rows) over a valid/ready stream and replays it as a `weight_start` pulse plus SYSTOLIC_SIZE `weight_valid` beats. It samples the recovery verdict only after the full tile has been delivered, and reports the result as pass or fail. On a pass, it generates the normal-operation row read addresses for the systolic array under a ready handshake.

---
 rtl/bisr_pkg.sv | 25 ++
 rtl/bisr_beat_counter.sv | 25 ++
 rtl/bisr_weight_loader.sv | 170 +++++++++++++++++
 tb/tb_bisr_weight_loader.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bisr_pkg.sv
// Shared types for the BISR weight loader: FSM state encoding and a
// helper that tells which states accept a new tile request.
package bisr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_LOAD   = 3'd2,
    ST_SETTLE = 3'd3,
    ST_CHECK  = 3'd4,
    ST_READY  = 3'd5,
    ST_READ   = 3'd6,
    ST_FAIL   = 3'd7
  } loader_state_t;

  // FAIL is included: a tile reload is the only way out of a failed verdict.
  function automatic logic accepts_tile(input loader_state_t s);
    return (s == ST_IDLE) || (s == ST_READY) || (s == ST_FAIL);
  endfunction

  function automatic logic is_busy_state(input loader_state_t s);
    return (s != ST_IDLE) && (s != ST_READY);
  endfunction

endpackage

// File: rtl/bisr_beat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module bisr_beat_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != MAX_V)) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/bisr_weight_loader.sv
// Tile sequencer ahead of BISR weight allocation: load, verdict, read sweep.
// Optional verdict watchdog is enabled with `define BISR_LOADER_TIMEOUT_EN.
module bisr_weight_loader
  import bisr_pkg::*;
#(
  parameter int SYSTOLIC_SIZE  = 8,
  parameter int WEIGHT_WIDTH   = 8,
  parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  tile_start,
  input  logic                                  s_valid,
  input  logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] s_data,
  output logic                                  s_ready,
  output logic                                  weight_start,
  output logic                                  weight_valid,
  output logic [SYSTOLIC_SIZE*WEIGHT_WIDTH-1:0] input_weights,
  input  logic                                  recovery_done,
  input  logic                                  recovery_success,
  input  logic                                  compute_start,
  input  logic                                  rd_ready,
  output logic [ADDR_WIDTH-1:0]                 read_addr,
  output logic                                  read_valid,
  output logic                                  tile_ok,
  output logic                                  tile_fail,
  output logic                                  busy,
  output loader_state_t                         dbg_state
);

  // Handshakes: a row moves when s_valid & s_ready in the same cycle; a read
  // address is consumed when read_valid & rd_ready. Neither side may drop a
  // pending address/row; read_addr holds while rd_ready is low.

  localparam int                  CW        = ADDR_WIDTH + 1;
  localparam logic [CW-1:0]       BEATS     = CW'(SYSTOLIC_SIZE);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(SYSTOLIC_SIZE - 1);

  loader_state_t   state;
  logic [CW-1:0]   beat_cnt;
  logic            beat_clr;
  logic            beat_en;
  logic            tile_go;
  logic            sweep_go;
  logic            rd_en;
  logic            rd_last;
  logic            to_expired;

  assign dbg_state = state;
  assign s_ready   = (state == ST_LOAD) && (beat_cnt < BEATS);
  assign beat_en   = s_valid && s_ready;
  assign beat_clr  = (state == ST_START);
  assign tile_go   = tile_start && accepts_tile(state);
  assign sweep_go  = (state == ST_READY) && compute_start && !tile_start;
  assign rd_en     = (state == ST_READ) && rd_ready;
  assign rd_last   = rd_en && (read_addr == LAST_ADDR);

  bisr_beat_counter #(
    .WIDTH (CW),
    .MAX   (SYSTOLIC_SIZE)
  ) u_beat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (beat_clr),
    .en    (beat_en),
    .count (beat_cnt)
  );

  // The read counter is the registered read_addr; it wraps to 0 on the last beat.
  bisr_beat_counter #(
    .WIDTH (ADDR_WIDTH),
    .MAX   (SYSTOLIC_SIZE - 1)
  ) u_read_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (rd_last || sweep_go),
    .en    (rd_en),
    .count (read_addr)
  );

`ifdef BISR_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  bisr_beat_counter #(
    .WIDTH (TW),
    .MAX   (TIMEOUT_CYCLES - 1)
  ) u_to_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state != ST_CHECK),
    .en    (1'b1),
    .count (to_cnt)
  );

  // Expires on the last of TIMEOUT_CYCLES sampled CHECK cycles.
  assign to_expired = (to_cnt == TW'(TIMEOUT_CYCLES - 1));
`else
  assign to_expired = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      weight_start  <= 1'b0;
      weight_valid  <= 1'b0;
      input_weights <= '0;
      read_valid    <= 1'b0;
      tile_ok       <= 1'b0;
      tile_fail     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      weight_start <= 1'b0;
      weight_valid <= beat_en;
      if (beat_en) begin
        input_weights <= s_data;
      end

      if (tile_go) begin
        state        <= ST_START;
        weight_start <= 1'b1;
        read_valid   <= 1'b0;
        tile_ok      <= 1'b0;
        tile_fail    <= 1'b0;
        busy         <= 1'b1;
      end else begin
        case (state)
          ST_START: state <= ST_LOAD;
          // Leave LOAD one cycle after the last beat so its weight_valid is seen first.
          ST_LOAD: begin
            if (beat_cnt == BEATS) begin
              state <= ST_SETTLE;
            end
          end
          ST_SETTLE: state <= ST_CHECK;
          ST_CHECK: begin
            if (recovery_done && recovery_success) begin
              state   <= ST_READY;
              tile_ok <= 1'b1;
              busy    <= 1'b0;
            end else if (recovery_done || to_expired) begin
              state     <= ST_FAIL;
              tile_fail <= 1'b1;
            end
          end
          ST_READY: begin
            if (sweep_go) begin
              state      <= ST_READ;
              read_valid <= 1'b1;
              busy       <= 1'b1;
            end
          end
          ST_READ: begin
            if (rd_last) begin
              state      <= ST_READY;
              read_valid <= 1'b0;
              busy       <= 1'b0;
            end
          end
          ST_IDLE, ST_FAIL: begin
            busy <= is_busy_state(state);
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bisr_weight_loader.sv
// Directed self-checking bench for bisr_weight_loader (8x8 weights).
module tb_bisr_weight_loader;
  import bisr_pkg::*;

  localparam int N  = 8;
  localparam int WW = 8;
  localparam int AW = 3;

  logic            clk;
  logic            rst_n;
  logic            tile_start;
  logic            s_valid;
  logic [N*WW-1:0] s_data;
  logic            s_ready;
  logic            weight_start;
  logic            weight_valid;
  logic [N*WW-1:0] input_weights;
  logic            recovery_done;
  logic            recovery_success;
  logic            compute_start;
  logic            rd_ready;
  logic [AW-1:0]   read_addr;
  logic            read_valid;
  logic            tile_ok;
  logic            tile_fail;
  logic            busy;
  loader_state_t   dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  bisr_weight_loader #(
    .SYSTOLIC_SIZE  (N),
    .WEIGHT_WIDTH   (WW),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .tile_start       (tile_start),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .weight_start     (weight_start),
    .weight_valid     (weight_valid),
    .input_weights    (input_weights),
    .recovery_done    (recovery_done),
    .recovery_success (recovery_success),
    .compute_start    (compute_start),
    .rd_ready         (rd_ready),
    .read_addr        (read_addr),
    .read_valid       (read_valid),
    .tile_ok          (tile_ok),
    .tile_fail        (tile_fail),
    .busy             (busy),
    .dbg_state        (dbg_state)
  );

  // Clock and global time limit.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit reached");
  end

  // ---- helpers ----
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*WW-1:0] row_of(input int v);
    logic [7:0] b;
    b = v[7:0];
    return {N{b}};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n            = 1'b0;
    tile_start       = 1'b0;
    s_valid          = 1'b0;
    s_data           = '0;
    recovery_done    = 1'b0;
    recovery_success = 1'b0;
    compute_start    = 1'b0;
    rd_ready         = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_weight_start"}, weight_start, 0);
    check({tag, "_weight_valid"}, weight_valid, 0);
    check({tag, "_input_weights"}, input_weights, 0);
    check({tag, "_read_addr"}, read_addr, 0);
    check({tag, "_read_valid"}, read_valid, 0);
    check({tag, "_tile_ok"}, tile_ok, 0);
    check({tag, "_tile_fail"}, tile_fail, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  // tile_start at T -> weight_start at T+1 -> LOAD with s_ready at T+2.
  task automatic start_tile();
    tile_start = 1'b1;
    step();
    tile_start = 1'b0;
    check("start_weight_start", weight_start, 1);
    check("start_busy", busy, 1);
    check("start_state", dbg_state, ST_START);
    step();
    check("load_weight_start", weight_start, 0);
    check("load_state", dbg_state, ST_LOAD);
  endtask

  task automatic drive_beats(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      check("beat_s_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data  = row_of(first + i);
      step();
      check("beat_weight_valid", weight_valid, 1);
      check("beat_input_weights", input_weights, row_of(first + i));
    end
    s_valid = 1'b0;
    s_data  = '0;
  endtask

  // After the last beat: LOAD (s_ready low), SETTLE, CHECK, then verdict.
  task automatic verdict(input logic success, input string tag);
    check({tag, "_last_s_ready"}, s_ready, 0);
    step();
    check({tag, "_settle_state"}, dbg_state, ST_SETTLE);
    check({tag, "_settle_wv"}, weight_valid, 0);
    recovery_done    = 1'b1;
    recovery_success = success;
    step();
    check({tag, "_check_state"}, dbg_state, ST_CHECK);
    check({tag, "_check_tile_ok"}, tile_ok, 0);
    step();
    check({tag, "_tile_ok"}, tile_ok, success);
    check({tag, "_tile_fail"}, tile_fail, !success);
    check({tag, "_busy"}, busy, !success);
  endtask

  logic [AW-1:0] exp_addr [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
  logic          rdy_pat  [10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    // Clean tile with reset-state checks.
    rst_n = 1'b0;
    do_reset();
    check_all_zero("reset");
    check("reset_state", dbg_state, ST_IDLE);
    start_tile();
    drive_beats(1, 8);
    verdict(1'b1, "clean");
    check("clean_state", dbg_state, ST_READY);

    // Stalled load with a premature verdict held high the whole time.
    do_reset();
    recovery_done    = 1'b1;
    recovery_success = 1'b1;
    start_tile();
    check("stall_early_ok", tile_ok, 0);
    drive_beats(1, 7);
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_wv", weight_valid, 0);
      check("stall_tile_ok", tile_ok, 0);
      check("stall_state", dbg_state, ST_LOAD);
    end
    drive_beats(8, 1);
    verdict(1'b1, "stall");

    // Failed recovery: compute_start ignored, FAIL exits only on tile_start.
    do_reset();
    start_tile();
    drive_beats(8'h21, 8);
    verdict(1'b0, "failrec");
    check("failrec_state", dbg_state, ST_FAIL);
    compute_start = 1'b1;
    step();
    compute_start = 1'b0;
    check("failrec_read_valid", read_valid, 0);
    check("failrec_hold_state", dbg_state, ST_FAIL);
    check("failrec_sticky", tile_fail, 1);
    step();
    check("failrec_read_valid2", read_valid, 0);
    tile_start = 1'b1;
    step();
    tile_start = 1'b0;
    check("failrec_reload_state", dbg_state, ST_START);
    check("failrec_reload_ws", weight_start, 1);

    // Read sweep with backpressure on address 3.
    do_reset();
    start_tile();
    drive_beats(8'h11, 8);
    verdict(1'b1, "sweep");
    recovery_done = 1'b0;
    compute_start = 1'b1;
    step();
    compute_start = 1'b0;
    for (int j = 0; j < 10; j++) begin
      check("sweep_read_valid", read_valid, 1);
      check("sweep_read_addr", read_addr, exp_addr[j]);
      check("sweep_busy", busy, 1);
      rd_ready = rdy_pat[j];
      step();
    end
    rd_ready = 1'b0;
    check("sweep_end_valid", read_valid, 0);
    check("sweep_end_addr", read_addr, 0);
    check("sweep_end_state", dbg_state, ST_READY);
    check("sweep_end_busy", busy, 0);
    tile_start    = 1'b1;
    compute_start = 1'b1;
    step();
    tile_start    = 1'b0;
    compute_start = 1'b0;
    check("prio_state", dbg_state, ST_START);
    check("prio_read_valid", read_valid, 0);

    // Asynchronous reset mid-LOAD, then a fresh tile.
    do_reset();
    start_tile();
    drive_beats(8'h31, 5);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async");
    check("async_state", dbg_state, ST_IDLE);
    step();
    rst_n = 1'b1;
    step();
    check("async_idle_state", dbg_state, ST_IDLE);
    start_tile();
    drive_beats(8'h41, 8);
    verdict(1'b1, "fresh");

    // Verdict never arrives.
    do_reset();
    start_tile();
    drive_beats(8'h51, 8);
    check("to_last_s_ready", s_ready, 0);
    step();
    step();
    check("to_check_state", dbg_state, ST_CHECK);
`ifdef BISR_LOADER_TIMEOUT_EN
    for (int i = 0; i < 15; i++) begin
      step();
      check("to_waiting_fail", tile_fail, 0);
    end
    check("to_waiting_state", dbg_state, ST_CHECK);
    step();
    check("to_tile_fail", tile_fail, 1);
    check("to_state", dbg_state, ST_FAIL);
`else
    repeat (40) step();
    check("to_still_check", dbg_state, ST_CHECK);
    check("to_no_fail", tile_fail, 0);
    recovery_done    = 1'b1;
    recovery_success = 1'b1;
    step();
    check("to_late_ok", tile_ok, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
